pipeline_ctrl: RTL

Central stall/flush sequencer for the five-stage pipeline (IF, ID, EX, MEM, WB).
- Drives the stall_current_stage / stall_next_stage pairs of every inter-stage pipeline register (PC, IF_ID, ID_EX, EX_MEM, MEM_WB).
- Resolves load-use hazards, multi-cycle EX operations and data-RAM wait states.
- Sequences a pipeline-wide flush that may be deferred while the memory stage is blocked.

---
 rtl/pipeline_ctrl_pkg.sv | 28 ++
 rtl/pipeline_ctrl_if.sv | 35 +++
 rtl/pipeline_ctrl_hazard_detect.sv | 22 ++
 rtl/pipeline_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: shared stall-vector layout, canned stall patterns and
// sequencer state encodings for the five-stage pipeline controller.
package pipeline_ctrl_pkg;

    // One bit per inter-stage register; bit i stalls register i,
    // bit i+1 tells register i that its successor is stalled.
    localparam int unsigned STALL_W      = 5;
    localparam int unsigned STALL_PC     = 0;
    localparam int unsigned STALL_IF_ID  = 1;
    localparam int unsigned STALL_ID_EX  = 2;
    localparam int unsigned STALL_EX_MEM = 3;
    localparam int unsigned STALL_MEM_WB = 4;

    typedef logic [STALL_W-1:0] stall_t;

    // Freeze everything upstream of the register that receives the bubble.
    localparam stall_t STALL_NONE     = 5'b00000;
    localparam stall_t STALL_LOAD_USE = 5'b00011;  // bubble into ID_EX
    localparam stall_t STALL_EX_WAIT  = 5'b00111;  // bubble into EX_MEM
    localparam stall_t STALL_MEM_WAIT = 5'b01111;  // bubble into MEM_WB

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_EX_WAIT  = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard inputs from the pipeline stages and the
// stall/flush/error outputs of the sequencer.
interface pipeline_ctrl_if #(
    parameter int unsigned REG_ADDR_WIDTH = 5
);
    import pipeline_ctrl_pkg::*;

    logic                      id_read_en_1;
    logic [REG_ADDR_WIDTH-1:0] id_read_addr_1;
    logic                      id_read_en_2;
    logic [REG_ADDR_WIDTH-1:0] id_read_addr_2;
    logic                      ex_ram_read_flag;
    logic [REG_ADDR_WIDTH-1:0] ex_write_reg_addr;
    logic                      ex_busy;
    logic                      ram_busy;
    logic                      flush_req;
    stall_t                    stall;
    logic                      flush;
    logic                      mem_timeout;

    // Pipeline side: reports hazards, obeys stall/flush.
    modport master (
        output id_read_en_1, id_read_addr_1, id_read_en_2, id_read_addr_2,
               ex_ram_read_flag, ex_write_reg_addr, ex_busy, ram_busy, flush_req,
        input  stall, flush, mem_timeout
    );

    // Controller side.
    modport slave (
        input  id_read_en_1, id_read_addr_1, id_read_en_2, id_read_addr_2,
               ex_ram_read_flag, ex_write_reg_addr, ex_busy, ram_busy, flush_req,
        output stall, flush, mem_timeout
    );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use compare between the load in EX and
// the source operands of the instruction in ID. r0 never creates a hazard.
module hazard_detect #(
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      id_read_en_1,
    input  logic [REG_ADDR_WIDTH-1:0] id_read_addr_1,
    input  logic                      id_read_en_2,
    input  logic [REG_ADDR_WIDTH-1:0] id_read_addr_2,
    input  logic                      ex_ram_read_flag,
    input  logic [REG_ADDR_WIDTH-1:0] ex_write_reg_addr,
    output logic                      load_use
);

    // Hazard while a load in EX targets a register that ID is about to read.
    always_comb begin
        load_use = ex_ram_read_flag && (ex_write_reg_addr != '0) &&
                   ((id_read_en_1 && (id_read_addr_1 == ex_write_reg_addr)) ||
                    (id_read_en_2 && (id_read_addr_2 == ex_write_reg_addr)));
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush sequencer for the IF/ID/EX/MEM/WB pipeline.
// Optional build macro PIPE_CTRL_PERF_EN adds stall-cycle and flush-pulse
// performance counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic                clk,
    input  logic                rst,
    pipeline_ctrl_if.slave      bus
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]         perf_stall_cnt,
    output logic [31:0]         perf_flush_cnt
`endif
);

    localparam logic [CNT_WIDTH-1:0] TIMEOUT_VAL = CNT_WIDTH'(TIMEOUT_CYCLES);

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   wait_cnt_q, wait_cnt_d;
    logic                   flush_pend_q, flush_pend_d;
    logic                   mem_timeout_q, mem_timeout_d;
    logic                   load_use;
    logic                   flush_any;
    logic                   flush_now;
    stall_t                 stall_o;
    logic                   flush_o;

    hazard_detect #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_hazard_detect (
        .id_read_en_1      (bus.id_read_en_1),
        .id_read_addr_1    (bus.id_read_addr_1),
        .id_read_en_2      (bus.id_read_en_2),
        .id_read_addr_2    (bus.id_read_addr_2),
        .ex_ram_read_flag  (bus.ex_ram_read_flag),
        .ex_write_reg_addr (bus.ex_write_reg_addr),
        .load_use          (load_use)
    );

    // A flush (fresh or deferred) can only leave once MEM has finished.
    always_comb begin
        flush_any = bus.flush_req | flush_pend_q;
        flush_now = flush_any & ~bus.ram_busy;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_RUN;
        else      state_q <= state_d;
    end

    // FSM next state; a flush aborts any EX operation and restarts in RUN.
    always_comb begin
        state_d = state_q;
        if (flush_now) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.ram_busy)     state_d = ST_MEM_WAIT;
                    else if (bus.ex_busy) state_d = ST_EX_WAIT;
                end
                ST_EX_WAIT: begin
                    if (bus.ram_busy)      state_d = ST_MEM_WAIT;
                    else if (!bus.ex_busy) state_d = ST_RUN;
                end
                ST_MEM_WAIT: begin
                    if (!bus.ram_busy) state_d = bus.ex_busy ? ST_EX_WAIT : ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // FSM outputs: zero-latency stall/flush, all quiet while in reset.
    always_comb begin
        stall_o = STALL_NONE;
        flush_o = 1'b0;
        if (rst) begin
            flush_o = flush_now;
            if (flush_now)         stall_o = STALL_NONE;
            else if (bus.ram_busy) stall_o = STALL_MEM_WAIT;
            else if (bus.ex_busy)  stall_o = STALL_EX_WAIT;
            else if (load_use)     stall_o = STALL_LOAD_USE;
        end
    end

    // Wait-cycle counter, sticky timeout and deferred-flush bookkeeping.
    always_comb begin
        wait_cnt_d = '0;
        if (bus.ram_busy) begin
            wait_cnt_d = (wait_cnt_q >= TIMEOUT_VAL) ? wait_cnt_q : wait_cnt_q + 1'b1;
        end
        mem_timeout_d = mem_timeout_q | (wait_cnt_d == TIMEOUT_VAL);
        flush_pend_d  = flush_any & bus.ram_busy;
    end

    // Registers for counter, timeout flag and pending flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            flush_pend_q  <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            flush_pend_q  <= flush_pend_d;
        end
    end

    assign bus.stall       = stall_o;
    assign bus.flush       = flush_o;
    assign bus.mem_timeout = mem_timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    // Free-running wrap-around event counters.
    always_comb begin
        perf_stall_d = perf_stall_q + {31'b0, (stall_o != STALL_NONE)};
        perf_flush_d = perf_flush_q + {31'b0, flush_o};
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule
